// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: default widths, ALU select codes
// and the sequencer state encoding.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned SEL_W_DEF  = 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_SHL  = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_ROL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_XOR  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd11;
  localparam logic [3:0] ALU_NAND = 4'd12;
  localparam logic [3:0] ALU_XNOR = 4'd13;
  localparam logic [3:0] ALU_GT   = 4'd14;
  localparam logic [3:0] ALU_EQ   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_RESULT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on rd_data whenever empty is low.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: queues commands, drives them onto the ALU inputs one
// at a time, waits SETTLE cycles, then returns each captured result in command order.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic [SEL_W-1:0]  res_sel,
  output logic              busy
);

  localparam int unsigned FIFO_W = 2 * DATA_W + SEL_W;
  localparam int unsigned CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_pop;
  logic               w_capture;
  logic               w_res_clr;

  logic               w_push;
  logic [FIFO_W-1:0]  w_fifo_wr;
  logic [FIFO_W-1:0]  w_fifo_rd;
  logic               w_full;
  logic               w_empty;
  logic [FCNT_W-1:0]  w_count;

  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [SEL_W-1:0]   r_alu_sel;
  logic               r_res_valid;
  logic [DATA_W-1:0]  r_res_data;
  logic               r_res_carry;
  logic [SEL_W-1:0]   r_res_sel;

  assign cmd_ready = !w_full && !rst;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_fifo_wr = {cmd_a, cmd_b, cmd_sel};

  alu_cmd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (w_fifo_wr),
    .pop     (w_pop),
    .rd_data (w_fifo_rd),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_res_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESULT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RESULT: begin
        if (r_res_valid && res_ready) begin
          w_res_clr = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = ST_DRIVE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ALU drive holds the last command after capture so ALU_Out stays stable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_sel   <= '0;
    end else begin
      if (w_pop) begin
        r_alu_a   <= w_fifo_rd[FIFO_W-1 -: DATA_W];
        r_alu_b   <= w_fifo_rd[SEL_W +: DATA_W];
        r_alu_sel <= w_fifo_rd[SEL_W-1:0];
      end
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= alu_out;
        r_res_carry <= alu_carry;
        r_res_sel   <= r_alu_sel;
      end else if (w_res_clr) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_sel   = r_res_sel;
  assign busy      = (r_state != ST_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer driving a behavioural 8-bit ALU.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic [3:0] res_sel;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q [$];
  int  cyc = 0;
  int  prev_cyc = 0;
  logic have_prev = 1'b0;
  logic gap_en = 1'b0;
  logic [7:0] sweep_exp [16];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DATA_W (8),
    .SEL_W  (4),
    .DEPTH  (4),
    .SETTLE (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_sel   (res_sel),
    .busy      (busy)
  );

  // Behavioural 8-bit ALU; CarryOut is always the carry of A+B
  logic [8:0] alu_sum;
  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_carry = alu_sum[8];
  always_comb begin
    alu_out = 8'h00;
    case (alu_sel)
      ALU_ADD:  alu_out = alu_a + alu_b;
      ALU_SUB:  alu_out = alu_a - alu_b;
      ALU_MUL:  alu_out = 8'(alu_a * alu_b);
      ALU_DIV:  alu_out = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
      ALU_SHL:  alu_out = alu_a << 1;
      ALU_SHR:  alu_out = alu_a >> 1;
      ALU_ROL:  alu_out = {alu_a[6:0], alu_a[7]};
      ALU_ROR:  alu_out = {alu_a[0], alu_a[7:1]};
      ALU_AND:  alu_out = alu_a & alu_b;
      ALU_OR:   alu_out = alu_a | alu_b;
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_NOR:  alu_out = ~(alu_a | alu_b);
      ALU_NAND: alu_out = ~(alu_a & alu_b);
      ALU_XNOR: alu_out = ~(alu_a ^ alu_b);
      ALU_GT:   alu_out = (alu_a > alu_b) ? 8'h01 : 8'h00;
      ALU_EQ:   alu_out = (alu_a == alu_b) ? 8'h01 : 8'h00;
      default:  alu_out = 8'h00;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every result transfer is checked against the head of the scoreboard
  always @(negedge clk) begin
    logic [12:0] e;
    cyc++;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", 32'(res_data), 32'(e[7:0]));
        chk("res_carry", 32'(res_carry), 32'(e[8]));
        chk("res_sel", 32'(res_sel), 32'(e[12:9]));
        if (gap_en && have_prev) chk("result_gap", 32'(cyc - prev_cyc), 32'd2);
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic [7:0] ed, input logic ec);
    logic acc;
    acc = 1'b0;
    cmd_a = a;
    cmd_b = b;
    cmd_sel = sel;
    cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back({sel, ec, ed});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_res_valid();
    for (int k = 0; k < 50; k++) begin
      if (res_valid) break;
      @(posedge clk);
      #1;
    end
    chk("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    int idx;
    sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_sel = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single add with latency check
    res_ready = 1'b1;
    send(8'h0A, 8'h02, ALU_ADD, 8'h0C, 1'b0);
    @(negedge clk);
    chk("lat_before_e1", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("lat_after_e1", 32'(res_valid), 32'd0);
    chk("alu_a_loaded", 32'(alu_a), 32'h0A);
    @(negedge clk);
    chk("lat_after_e2", 32'(res_valid), 32'd1);
    @(posedge clk);
    #1;
    wait_drain("drain_single");

    // Carry out
    send(8'hF6, 8'h0A, ALU_ADD, 8'h00, 1'b1);
    wait_drain("drain_carry");
    repeat (2) @(posedge clk);
    #1;

    // Select sweep, back-to-back
    have_prev = 1'b0;
    gap_en = 1'b1;
    for (int s = 0; s < 16; s++) send(8'h0A, 8'h02, 4'(s), sweep_exp[s], 1'b0);
    wait_drain("drain_sweep");
    @(posedge clk);
    #1;
    gap_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: DEPTH+1 commands accepted
    res_ready = 1'b0;
    acc_n = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_a = 8'h10 + 8'(idx);
      cmd_b = 8'h01;
      cmd_sel = ALU_ADD;
      cmd_valid = 1'b1;
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back({ALU_ADD, 1'b0, 8'h11 + 8'(idx)});
        acc_n++;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 32'(acc_n), 32'd5);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_res_hold", 32'(res_data), 32'h11);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_drain("drain_bp");
    @(negedge clk);
    chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;

    // Reset while driving
    res_ready = 1'b0;
    send(8'h20, 8'h01, ALU_SUB, 8'h1F, 1'b0);
    send(8'h20, 8'h02, ALU_SUB, 8'h1E, 1'b0);
    send(8'h20, 8'h03, ALU_SUB, 8'h1D, 1'b0);
    wait_res_valid();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("rst_in_drive", 32'(dut.r_state), 32'(ST_DRIVE));
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    chk("midrst_alu_b", 32'(alu_b), 32'd0);
    chk("midrst_alu_sel", 32'(alu_sel), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("postrst_no_result", 32'(res_valid), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Simultaneous push and pop at count 2
    res_ready = 1'b0;
    send(8'h55, 8'h00, ALU_XOR, 8'h55, 1'b0);
    send(8'h55, 8'h01, ALU_XOR, 8'h54, 1'b0);
    send(8'h55, 8'h02, ALU_XOR, 8'h57, 1'b0);
    wait_res_valid();
    chk("pp_count_before", 32'(dut.w_count), 32'd2);
    res_ready = 1'b1;
    send(8'h55, 8'h03, ALU_XOR, 8'h56, 1'b0);
    res_ready = 1'b0;
    @(negedge clk);
    chk("pp_count_after", 32'(dut.w_count), 32'd2);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_drain("drain_pp");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
